// File: rtl/fc_layer_sched_pkg.sv
// Shared types and constants for the dense-layer sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_UPDATE,
        ST_TX,
        ST_WAIT_TX
    } fc_state_t;

    localparam int FC_N_OUT   = 10;
    localparam int FC_N_CHUNK = 4;
    localparam int FC_LANES   = 16;

    function automatic int unsigned fc_rom_addr(input int unsigned neuron,
                                                input int unsigned chunk,
                                                input int unsigned n_chunk);
        return neuron * n_chunk + chunk;
    endfunction

endpackage

// File: rtl/fc_lat_pipe.sv
// DEPTH-cycle 1-bit delay line with synchronous clear; aligns acc_en with ROM data.
module fc_lat_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fc_layer_sched.sv
// Dense-layer sequencer: walks neurons x chunks, strobes accumulate/argmax, then hands off to UART.
module fc_layer_sched
    import fc_pkg::*;
#(
    parameter int N_OUT   = FC_N_OUT,
    parameter int N_CHUNK = FC_N_CHUNK,
    parameter int ROM_LAT = 1,
    parameter int ADDR_W  = 6,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strt,
    input  logic              tx_done,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        feat_idx,
    output logic [IDX_W-1:0]  neuron_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              upd,
    output logic              trmt,
    output logic              done
);

    localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    fc_state_t         state_q, state_d;
    logic [IDX_W-1:0]  neuron_q, neuron_d;
    logic [1:0]        chunk_q, chunk_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            neuron_q <= '0;
            chunk_q  <= '0;
            dcnt_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
            chunk_q  <= chunk_d;
            dcnt_q   <= dcnt_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        chunk_d  = chunk_q;
        dcnt_d   = dcnt_q;
        addr_d   = addr_q;
        issue    = 1'b0;
        acc_clr  = 1'b0;
        upd      = 1'b0;
        trmt     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (strt) begin
                    acc_clr  = 1'b1;
                    neuron_d = '0;
                    chunk_d  = '0;
                    dcnt_d   = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue  = 1'b1;
                addr_d = ADDR_W'(fc_rom_addr(32'(neuron_q), 32'(chunk_q), N_CHUNK));
                if (chunk_q == 2'(N_CHUNK - 1)) begin
                    chunk_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    chunk_d = chunk_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DW'(ROM_LAT - 1)) begin
                    dcnt_d  = '0;
                    state_d = ST_UPDATE;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ST_UPDATE: begin
                // neuron_idx still names the finished neuron so the bias ROM output is stable
                upd     = 1'b1;
                acc_clr = 1'b1;
                if (neuron_q == IDX_W'(N_OUT - 1)) begin
                    state_d = ST_TX;
                end else begin
                    neuron_d = neuron_q + IDX_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_TX: begin
                trmt    = 1'b1;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    done     = 1'b1;
                    neuron_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    fc_lat_pipe #(
        .DEPTH(ROM_LAT)
    ) u_lat_pipe (
        .clk  (clk),
        .clr_i(rst),
        .d_i  (issue),
        .q_o  (acc_en)
    );

    assign busy       = (state_q != ST_IDLE);
    assign rom_addr   = addr_d;
    assign feat_idx   = chunk_q;
    assign neuron_idx = neuron_q;

endmodule

// File: tb/tb_fc_layer_sched.sv
// Self-checking bench for fc_layer_sched at ROM_LAT=1 and ROM_LAT=2.
`timescale 1ns/1ps
module tb_fc_layer_sched;

    localparam int NO = 10;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst, strt, tx_done;

    logic       busy1, acc_clr1, acc_en1, upd1, trmt1, done1;
    logic [5:0] rom_addr1;
    logic [1:0] feat_idx1;
    logic [3:0] neuron_idx1;

    logic       busy2, acc_clr2, acc_en2, upd2, trmt2, done2;
    logic [5:0] rom_addr2;
    logic [1:0] feat_idx2;
    logic [3:0] neuron_idx2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_layer_sched dut (
        .clk(clk), .rst(rst), .strt(strt), .tx_done(tx_done),
        .busy(busy1), .rom_addr(rom_addr1), .feat_idx(feat_idx1), .neuron_idx(neuron_idx1),
        .acc_clr(acc_clr1), .acc_en(acc_en1), .upd(upd1), .trmt(trmt1), .done(done1)
    );

    fc_layer_sched #(.ROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .strt(strt), .tx_done(tx_done),
        .busy(busy2), .rom_addr(rom_addr2), .feat_idx(feat_idx2), .neuron_idx(neuron_idx2),
        .acc_clr(acc_clr2), .acc_en(acc_en2), .upd(upd2), .trmt(trmt2), .done(done2)
    );

    // Expected {busy, acc_clr, acc_en, upd, trmt, done} at cycle k after the strt cycle (k=0).
    function automatic logic [5:0] model_ctl(int k, int lat, int acc, int rk);
        int p, last, j;
        logic b, clr, en, u, t, d;
        p    = NC + lat + 1;
        last = NO * p;
        if ((rk >= 0 && k > rk) || k > acc) return 6'b0;
        b   = (k >= 1);
        clr = (k == 0);
        en  = 1'b0;
        u   = 1'b0;
        if (k >= 1 && k <= last) begin
            j   = (k - 1) % p;
            en  = (j >= lat) && (j < NC + lat);
            u   = (j == p - 1);
            clr = u;
        end
        t = (k == last + 1);
        d = (k == acc);
        return {b, clr, en, u, t, d};
    endfunction

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1; strt = 1'b0; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obs = {busy1, acc_clr1, acc_en1, upd1, trmt1, done1};
            checks++;
            if (obs !== 6'b0 || rom_addr1 !== 6'd0 || feat_idx1 !== 2'd0 || neuron_idx1 !== 4'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got ctl=%b addr=%0d feat=%0d nrn=%0d want all 0",
                         i, obs, rom_addr1, feat_idx1, neuron_idx1);
            end
            checks++;
            if ({busy2, acc_en2, rom_addr2, neuron_idx2} !== '0) begin
                errors++;
                $display("FAIL reset_idle_lat2 cyc=%0d got busy=%b en=%b addr=%0d nrn=%0d want 0",
                         i, busy2, acc_en2, rom_addr2, neuron_idx2);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // One inference: strt at k=0, tx_done held from tx_start, optional spurious strt,
    // optional reset at cycle rk (rk<0: none), optional reset before the run.
    task automatic test_inference(string name, int lat, int tx_start, bit spur, int rk, bit pre);
        int p, last, acc, kend, n, j;
        logic [5:0] obs, exp_ctl;
        logic [5:0] addr_o;
        logic [1:0] feat_o;
        logic [3:0] nrn_o;
        p    = NC + lat + 1;
        last = NO * p;
        acc  = (tx_start > last + 2) ? tx_start : last + 2;
        kend = (rk >= 0) ? rk + 3 : acc + 2;
        if (pre) begin
            rst = 1'b1; strt = 1'b0; tx_done = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k <= kend; k++) begin
            rst     = (k == rk);
            strt    = (k == 0) ||
                      (spur && k >= 1 && k < acc && (rk < 0 || k <= rk) &&
                       (k == 20 || k == 65 || $urandom_range(0, 3) == 0));
            tx_done = (k >= tx_start) && (k <= acc) && (rk < 0 || k <= rk);
            @(negedge clk);
            if (lat == 1) begin
                obs = {busy1, acc_clr1, acc_en1, upd1, trmt1, done1};
                addr_o = rom_addr1; feat_o = feat_idx1; nrn_o = neuron_idx1;
            end else begin
                obs = {busy2, acc_clr2, acc_en2, upd2, trmt2, done2};
                addr_o = rom_addr2; feat_o = feat_idx2; nrn_o = neuron_idx2;
            end
            exp_ctl = model_ctl(k, lat, acc, rk);
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL %s_ctl k=%0d lat=%0d got {busy,clr,en,upd,trmt,done}=%b want %b",
                         name, k, lat, obs, exp_ctl);
            end
            if (k >= 1 && k <= last && (rk < 0 || k <= rk)) begin
                n = (k - 1) / p;
                j = (k - 1) % p;
                checks++;
                if (nrn_o !== 4'(n)) begin
                    errors++;
                    $display("FAIL %s_neuron k=%0d got %0d want %0d", name, k, nrn_o, n);
                end
                if (j < NC) begin
                    checks++;
                    if (addr_o !== 6'(n * NC + j) || feat_o !== 2'(j)) begin
                        errors++;
                        $display("FAIL %s_addr k=%0d got addr=%0d feat=%0d want addr=%0d feat=%0d",
                                 name, k, addr_o, feat_o, n * NC + j, j);
                    end
                end
            end
            if (rk >= 0 && k > rk) begin
                checks++;
                if (addr_o !== 6'd0 || feat_o !== 2'd0 || nrn_o !== 4'd0) begin
                    errors++;
                    $display("FAIL %s_rst_flush k=%0d got addr=%0d feat=%0d nrn=%0d want 0",
                             name, k, addr_o, feat_o, nrn_o);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0; strt = 1'b0; tx_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; strt = 1'b0; tx_done = 1'b0;
        test_reset();
        test_inference("full",         1, 70, 1'b0, -1, 1'b1);
        test_inference("handshake",    1, 61, 1'b0, -1, 1'b1);
        test_inference("ignore_strt",  1, 70, 1'b1, -1, 1'b1);
        test_inference("back_to_back", 1, int'($urandom_range(61, 72)), 1'b0, -1, 1'b0);
        test_inference("rst_mid",      1, 70, 1'b0, 33, 1'b1);
        test_inference("after_rst",    1, 70, 1'b0, -1, 1'b0);
        test_inference("rst_rand",     1, 70, 1'b1, int'($urandom_range(1, 70)), 1'b1);
        test_inference("after_rst2",   1, 64, 1'b0, -1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            test_inference("random", 1, int'($urandom_range(61, 75)), 1'b1, -1, 1'b1);
        end
        test_inference("lat2",         2, 80, 1'b0, -1, 1'b1);
        test_inference("lat2_hs",      2, 71, 1'b1, -1, 1'b1);
        test_inference("lat2_rst",     2, 80, 1'b0, int'($urandom_range(1, 75)), 1'b1);
        test_inference("lat2_rand",    2, int'($urandom_range(71, 85)), 1'b1, -1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_layer_sched.md
Name: fc_layer_sched

Overview:
Sequencer for the final fully-connected (dense) layer datapath: 16 parallel MAC lanes, one 36-bit accumulator, per-neuron bias, ReLU and running argmax.
Walks N_OUT output neurons × N_CHUNK input chunks. Drives weight-ROM and feature-buffer addresses, accumulator clear/enable, bias address and the argmax update strobe.
Then hands the winning digit to the UART transmitter through a trmt/tx_done handshake. Sits between the layer-4 output buffer and the UART TX.

Parameters:
N_OUT, 10, number of output neurons (digits)
N_CHUNK, 4, 16-wide input chunks per neuron (64 inputs)
ROM_LAT, 1, read latency in cycles of the weight ROM and feature buffer (≥1)
ADDR_W, 6, weight ROM address width, must satisfy 2^ADDR_W ≥ N_OUT*N_CHUNK
IDX_W, 4, neuron index width, must satisfy 2^IDX_W ≥ N_OUT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
strt  in  1  start one inference; honoured only in IDLE
tx_done  in  1  UART finished sending result byte
busy  out  1  high whenever state ≠ IDLE
rom_addr  out  ADDR_W  weight ROM read address = neuron*N_CHUNK + chunk
feat_idx  out  2  feature-buffer chunk select (= chunk)
neuron_idx  out  IDX_W  current neuron; also drives bias ROM address
acc_clr  out  1  clear accumulator at next edge
acc_en  out  1  accumulate lane sum at next edge
upd  out  1  argmax compare/update strobe; accumulator final this cycle
trmt  out  1  one-cycle pulse: argmax result valid, start UART send
done  out  1  one-cycle pulse on return to IDLE after tx_done

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. On a clk edge with rst=1, state=IDLE, all counters 0, and every output 0 (including busy, rom_addr, feat_idx and neuron_idx).
- States: IDLE, ISSUE, DRAIN, UPDATE, TX, WAIT_TX. Package enum, 3 bits.
- IDLE, strt=1: assert acc_clr this cycle; clear the neuron and chunk counters; go to ISSUE. strt in any other state is ignored.
- ISSUE: one address per cycle, rom_addr = neuron*N_CHUNK + chunk, feat_idx = chunk.
  - chunk increments each cycle.
  - After chunk N_CHUNK-1 is issued, go to DRAIN; chunk wraps to 0.
- acc_en is asserted exactly ROM_LAT cycles after each ISSUE cycle, via a shift register.
  - acc_en is never asserted in the same cycle as acc_clr.
- DRAIN: stay ROM_LAT cycles, then go to UPDATE. The last acc_en lands in the final DRAIN cycle.
- UPDATE: upd=1 and acc_clr=1 for one cycle. neuron_idx still names the finished neuron, so the bias ROM output is stable.
  - If neuron = N_OUT-1, go to TX.
  - Otherwise increment neuron and go to ISSUE.
- Per-neuron cost: N_CHUNK + ROM_LAT + 1 cycles (6 at defaults).
- Latency: strt accepted at cycle t0 → UPDATE of neuron n at t0 + (n+1)(N_CHUNK+ROM_LAT+1) → trmt at t0 + N_OUT(N_CHUNK+ROM_LAT+1) + 1 (t0+61 at defaults).
- TX: trmt=1 for exactly one cycle, then go to WAIT_TX.
- WAIT_TX: hold all datapath controls 0 until tx_done=1.
  - On tx_done=1: done=1 that cycle, next state IDLE.
  - tx_done in any other state is ignored.
  - tx_done in the same cycle as the trmt pulse is not accepted.
- The block does not clear the argmax. The datapath clears the argmax on trmt.
- rom_addr holds its last value outside ISSUE. Verification checks rom_addr only while ISSUE is active.
- rst asserted mid-operation (any state): next edge gives IDLE with all outputs 0. There is no partial trmt, and any pending acc_en in the shift register is flushed.
- No wrap hazards: the neuron counter never exceeds N_OUT-1, and rom_addr never exceeds N_OUT*N_CHUNK-1.

Decomposition:
- Package fc_pkg holds:
  - state enum fc_state_t;
  - localparams FC_N_OUT=10, FC_N_CHUNK=4, FC_LANES=16;
  - a function computing rom_addr from neuron and chunk.
- Sub-module fc_lat_pipe: parameterised ROM_LAT-deep 1-bit delay line with synchronous clear. It generates acc_en from the ISSUE strobe.

Test Plan:
- Reset/idle: hold rst 3 cycles, then strt=0 for 10 cycles → every output 0, busy=0.
- Full inference, defaults: strt pulse at t0 →
  - rom_addr sequence 0,1,2,3 | 4..7 | … | 36..39;
  - acc_en at t0+2..t0+5, then every neuron (4 per neuron);
  - upd at t0+6, t0+12, …, t0+60;
  - trmt only at t0+61;
  - tx_done at t0+70 → done at t0+70, busy=0 at t0+71.
- Handshake: hold tx_done=1 continuously from t0+61 → not accepted on the trmt cycle; done at t0+62.
- Ignore strt: pulse strt at t0+20 and t0+65 (WAIT_TX) → sequence unchanged, no restart. A strt after done starts a new run with acc_clr.
- Reset mid-run: rst=1 at t0+33 → next cycle all outputs 0, IDLE. A later strt gives a full clean run with rom_addr starting at 0.
- ROM_LAT=2 build: each acc_en lags its rom_addr by 2 cycles, per-neuron period is 7, trmt at t0+71.
